// File: rtl/delay_config_ctrl.sv
// Shadow/active per-channel delay indices; a committed shadow set is applied atomically at a frame boundary.
// Optional macro DELAY_SLEW_EN: active indices step one count per frame toward the committed set.
module delay_config_ctrl #(
  parameter int NUM_CHANNELS = 4,
  parameter int BUFFER_SIZE  = 16,
  localparam int IDX_W = $clog2(BUFFER_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [2:0]                    cfg_chan,
  input  logic [IDX_W-1:0]              cfg_delay,
  input  logic                          commit,
  output logic [NUM_CHANNELS*IDX_W-1:0] delay_index,
  output logic                          pending,
  output logic                          busy,
  output logic                          update_pulse,
  output logic [1:0]                    err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED
`ifdef DELAY_SLEW_EN
    , SLEW
`endif
  } state_t;

  localparam logic [3:0]       NCH     = 4'(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(BUFFER_SIZE - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] shadow_q [NUM_CHANNELS];
  logic [IDX_W-1:0] shadow_d [NUM_CHANNELS];
  logic [IDX_W-1:0] active_q [NUM_CHANNELS];
  logic [IDX_W-1:0] active_d [NUM_CHANNELS];
  logic [1:0]       err_q, err_d;
  logic             pulse_q, pulse_d;

  logic             chan_oob, wr_ok, wr_bad, commit_ok, commit_bad;
  logic [IDX_W-1:0] wr_delay;

  assign cfg_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign chan_oob   = ({1'b0, cfg_chan} >= NCH);
  assign wr_ok      = cfg_valid && cfg_ready && !chan_oob;
  assign wr_bad     = cfg_valid && cfg_ready && chan_oob;
  assign commit_ok  = commit && cfg_ready;
  assign commit_bad = commit && !cfg_ready;

  // Clamping only matters for non-power-of-two depths.
  if ((1 << IDX_W) == BUFFER_SIZE) begin : g_no_clamp
    assign wr_delay = cfg_delay;
  end else begin : g_clamp
    assign wr_delay = (cfg_delay > MAX_IDX) ? MAX_IDX : cfg_delay;
  end

`ifdef DELAY_SLEW_EN
  logic [IDX_W-1:0] step_val [NUM_CHANNELS];
  logic             step_done;

  always_comb begin
    step_done = 1'b1;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      step_val[c] = active_q[c];
      if (active_q[c] < shadow_q[c])      step_val[c] = active_q[c] + 1'b1;
      else if (active_q[c] > shadow_q[c]) step_val[c] = active_q[c] - 1'b1;
      if (step_val[c] != shadow_q[c]) step_done = 1'b0;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    pulse_d  = 1'b0;
    shadow_d = shadow_q;
    active_d = active_q;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (wr_ok && (cfg_chan == 3'(c))) shadow_d[c] = wr_delay;
    // An accepted commit wipes the flags, even one raised by its own write.
    if (commit_ok) err_d = '0;
    else           err_d = err_q | {commit_bad, wr_bad};
    case (state_q)
      IDLE, LOAD: begin
        if (commit_ok)  state_d = ARMED;
        else if (wr_ok) state_d = LOAD;
      end
      ARMED: begin
        if (frame_start) begin
`ifdef DELAY_SLEW_EN
          active_d = step_val;
          if (step_done) begin
            pulse_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = SLEW;
          end
`else
          active_d = shadow_q;
          pulse_d  = 1'b1;
          state_d  = IDLE;
`endif
        end
      end
`ifdef DELAY_SLEW_EN
      SLEW: begin
        if (frame_start) begin
          active_d = step_val;
          if (step_done) begin
            pulse_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= '0;
      pulse_q <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      pulse_q  <= pulse_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pack
    assign delay_index[c*IDX_W +: IDX_W] = active_q[c];
  end

  assign pending      = (state_q == LOAD);
`ifdef DELAY_SLEW_EN
  assign busy         = (state_q == ARMED) || (state_q == SLEW);
`else
  assign busy         = (state_q == ARMED);
`endif
  assign update_pulse = pulse_q;
  assign err          = err_q;

endmodule

// File: tb/tb_delay_config_ctrl.sv
// Bench for delay_config_ctrl: directed literal checks plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_delay_config_ctrl;
  localparam int NCH = 4;
  localparam int BSZ = 16;
  localparam int IW  = $clog2(BSZ);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              commit = 1'b0;
  logic [2:0]        cfg_chan = '0;
  logic [IW-1:0]     cfg_delay = '0;
  logic              cfg_ready, pending, busy, update_pulse;
  logic [1:0]        err;
  logic [NCH*IW-1:0] delay_index;

  int n_chk = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  delay_config_ctrl #(.NUM_CHANNELS(NCH), .BUFFER_SIZE(BSZ)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_delay(cfg_delay), .commit(commit), .delay_index(delay_index),
    .pending(pending), .busy(busy), .update_pulse(update_pulse), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(input int ch);
    return int'(delay_index[ch*IW +: IW]);
  endfunction

  function automatic int clampv(input int d);
    return (d >= BSZ) ? BSZ - 1 : d;
  endfunction

  // Behavioural model: what the outputs must be after each rising edge.
  int      m_shadow [NCH];
  int      m_active [NCH];
  bit      m_load, m_armed, m_slew, m_pulse;
  bit [1:0] m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_shadow[c] = 0;
        m_active[c] = 0;
      end
      m_load = 0; m_armed = 0; m_slew = 0; m_pulse = 0; m_err = 0;
    end else begin
      bit bad, done;
      m_pulse = 0;
      if (!(m_armed || m_slew)) begin
        bad = cfg_valid && (int'(cfg_chan) >= NCH);
        if (cfg_valid && !bad) begin
          m_shadow[int'(cfg_chan)] = clampv(int'(cfg_delay));
          m_load = 1;
        end
        if (commit) begin
          m_err = 0; m_armed = 1; m_load = 0;
        end else if (bad) begin
          m_err[0] = 1;
        end
      end else begin
        if (commit) m_err[1] = 1;
        if (frame_start) begin
`ifdef DELAY_SLEW_EN
          done = 1;
          for (int c = 0; c < NCH; c++) begin
            if (m_active[c] < m_shadow[c])      m_active[c]++;
            else if (m_active[c] > m_shadow[c]) m_active[c]--;
            if (m_active[c] != m_shadow[c]) done = 0;
          end
          m_armed = 0; m_slew = !done; m_pulse = done;
`else
          for (int c = 0; c < NCH; c++) m_active[c] = m_shadow[c];
          m_armed = 0; m_pulse = 1;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      logic [NCH*IW-1:0] exp_idx;
      for (int c = 0; c < NCH; c++) exp_idx[c*IW +: IW] = IW'(m_active[c]);
      chk("model delay_index", 32'(delay_index), 32'(exp_idx));
      chk("model cfg_ready", 32'(cfg_ready), 32'(!(m_armed || m_slew)));
      chk("model busy", 32'(busy), 32'(m_armed || m_slew));
      chk("model pending", 32'(pending), 32'(m_load));
      chk("model update_pulse", 32'(update_pulse), 32'(m_pulse));
      chk("model err", 32'(err), 32'(m_err));
    end
  end

  task automatic drive(input bit v, input int ch, input int d, input bit cm, input bit fs);
    cfg_valid = v; cfg_chan = 3'(ch); cfg_delay = IW'(d); commit = cm; frame_start = fs;
    @(negedge clk);
    cfg_valid = 0; commit = 0; frame_start = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset delay_index", 32'(delay_index), 0);
    chk("reset cfg_ready", 32'(cfg_ready), 1);
    chk("reset err", 32'(err), 0);
    chk("reset busy", 32'(busy), 0);
    rst_n = 1;
    run_cmp = 1;

`ifdef DELAY_SLEW_EN
    drive(1, 1, 2, 1, 0);
    drive(0, 0, 0, 0, 1);
    chk("slew first step", idx(1), 1);
    chk("slew no early pulse", 32'(update_pulse), 0);
    drive(0, 0, 0, 0, 1);
    chk("slew reaches 2", idx(1), 2);
    chk("slew pulse at 2", 32'(update_pulse), 1);
    drive(1, 1, 6, 1, 0);
    drive(0, 0, 0, 0, 1);
    chk("slew step 3", idx(1), 3);
    chk("slew ready low", 32'(cfg_ready), 0);
    drive(1, 1, 0, 0, 0);
    chk("slew write refused", 32'(pending), 0);
    drive(0, 0, 0, 0, 1);
    chk("slew step 4", idx(1), 4);
    drive(0, 0, 0, 0, 1);
    chk("slew step 5", idx(1), 5);
    chk("slew pulse not yet", 32'(update_pulse), 0);
    drive(0, 0, 0, 0, 1);
    chk("slew step 6", idx(1), 6);
    chk("slew pulse at 6", 32'(update_pulse), 1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    chk("slew k0 pulse", 32'(update_pulse), 1);
    chk("slew k0 idle", 32'(busy), 0);
`else
    drive(1, 2, 5, 0, 0);
    chk("pending after write", 32'(pending), 1);
    drive(0, 0, 0, 1, 0);
    chk("busy after commit", 32'(busy), 1);
    chk("ready low armed", 32'(cfg_ready), 0);
    idle(9);
    chk("idx2 before frame", idx(2), 0);
    drive(0, 0, 0, 0, 1);
    chk("idx2 after frame", idx(2), 5);
    chk("pulse after frame", 32'(update_pulse), 1);
    chk("busy cleared", 32'(busy), 0);
    idle(1);
    chk("pulse one cycle", 32'(update_pulse), 0);
    drive(1, 5, 9, 0, 0);
    chk("bad chan err0", 32'(err), 1);
    chk("bad chan no load", 32'(pending), 0);
    drive(0, 0, 0, 1, 0);
    chk("commit clears err0", 32'(err), 0);
    drive(0, 0, 0, 0, 1);
    chk("shadow unchanged", 32'(delay_index), 32'h0500);
    drive(1, 1, 7, 0, 0);
    drive(0, 0, 0, 1, 1);
    chk("same-cycle frame ignored", idx(1), 0);
    drive(0, 0, 0, 1, 0);
    chk("commit while armed err1", 32'(err), 2);
    chk("ready low while armed", 32'(cfg_ready), 0);
    drive(0, 0, 0, 0, 1);
    chk("next frame applies", idx(1), 7);
    drive(1, 0, 3, 1, 0);
    chk("write+commit clears err", 32'(err), 0);
    drive(0, 0, 0, 0, 1);
    chk("write+commit applied", 32'(delay_index), 32'h0573);
    drive(1, 6, 0, 1, 0);
    chk("clear beats set", 32'(err), 0);
    drive(0, 0, 0, 0, 1);
`endif

    drive(1, 3, 9, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async rst delay_index", 32'(delay_index), 0);
    chk("async rst err", 32'(err), 0);
    chk("async rst cfg_ready", 32'(cfg_ready), 1);
    chk("async rst busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 3000; i++) begin
      int ch;
      if (i % 700 == 350) begin
        @(posedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end
      ch = ($urandom_range(0, 9) < 8) ? $urandom_range(0, NCH - 1) : $urandom_range(0, 7);
      drive($urandom_range(0, 9) < 4, ch, $urandom_range(0, BSZ - 1),
            $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_config_ctrl.md
Name: delay_config_ctrl

Overview:
- Configuration controller for the beamformer delay buffers.
- Accepts per-channel delay (read-index) writes from the MCU-facing interface into shadow registers.
- Applies them atomically to the active read indices at an I2S frame boundary, so buffer readout never sees a half-updated steering set.
- Sits between the config input pins and the delay_index inputs of the dual channel buffers.

Parameters:
- NUM_CHANNELS, 4, number of delay channels (max 8).
- BUFFER_SIZE, 16, depth of each channel buffer. Derived IDX_W = $clog2(BUFFER_SIZE).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- frame_start  input  1  one-cycle pulse at the start of each ws frame, synchronous to clk.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  controller can accept a write.
- cfg_chan  input  3  target channel.
- cfg_delay  input  IDX_W  requested delay index.
- commit  input  1  one-cycle request to apply the shadow set at the next frame.
- delay_index  output  NUM_CHANNELS*IDX_W  active indices, channel n at [n*IDX_W +: IDX_W].
- pending  output  1  shadow differs from the last commit (state LOAD).
- busy  output  1  commit armed or in progress.
- update_pulse  output  1  one cycle, high when the active set reaches the committed values.
- err  output  2  sticky flags: [0] channel out of range, [1] commit while busy.

Behaviour:
- Reset (async assert): state IDLE; all shadow and active indices 0; cfg_ready 1; pending 0; busy 0; update_pulse 0; err 0.
- Handshake: a write transfers on a posedge with cfg_valid && cfg_ready. cfg_ready = 1 in IDLE/LOAD, 0 in ARMED/SLEW. Writes are never queued.
- Write handling:
  - cfg_chan >= NUM_CHANNELS: write dropped, err[0] set.
  - cfg_delay >= BUFFER_SIZE (only possible when not a power of two): clamped to BUFFER_SIZE-1.
  - Otherwise the shadow register for that channel is updated the next cycle.
- States:
  - IDLE: an accepted valid write -> LOAD. commit -> ARMED (re-apply of the unchanged set is legal).
  - LOAD: further writes stay in LOAD. commit -> ARMED. A write and commit in the same cycle: the write is included in the commit.
  - ARMED: waits for frame_start. A frame_start in the same cycle as the commit does NOT apply; the next one does. On frame_start: active <= shadow, update_pulse = 1 the following cycle, -> IDLE. New delay_index is visible exactly one cycle after frame_start is sampled.
  - SLEW: only with the optional feature; see below.
- Outputs: busy = (ARMED || SLEW); pending = (state == LOAD).
- commit while ARMED/SLEW: ignored, err[1] set.
- err clearing: err bits clear only on reset or on an accepted commit in IDLE/LOAD. The commit clear takes priority over a same-cycle error set from that cycle's write.
- Reset mid-operation: async return to reset values. An armed commit is discarded; the active set goes to 0 immediately.
- Every output is registered; none is combinational from inputs except cfg_ready, which decodes state only.

Optional Feature:
- Macro: DELAY_SLEW_EN.
- Defined:
  - ARMED on frame_start -> SLEW instead of applying directly.
  - On that frame_start and each later one, every active index moves one step (+1 or -1) toward its shadow value.
  - When all channels match after a step: update_pulse the next cycle, -> IDLE.
  - A change of k steps takes k frames; k = 0 completes on the first frame_start.
  - This limits audible clicks on steering changes.
- Undefined: the SLEW state and its step logic are absent; ARMED applies in one step as above.

Test Plan:
- Reset: hold rst_n = 0 mid-frame with indices loaded -> delay_index = 0, err = 0, cfg_ready = 1, asynchronously, before any clk edge.
- Write chan 2 delay 5, commit, frame_start 10 cycles later -> delay_index[2] stays 0 until one cycle after frame_start, then 5. update_pulse high exactly 1 cycle. busy high from the cycle after commit until IDLE.
- Write chan 5 (NUM_CHANNELS = 4) -> shadow unchanged, err[0] = 1. Next commit in IDLE clears err[0].
- commit and frame_start in the same cycle -> no change. The next frame_start applies. A second commit while ARMED -> err[1] = 1, cfg_ready = 0 during ARMED.
- Write chan 0 delay 3 with commit in the same cycle -> delay_index[0] = 3 after the next frame_start.
- DELAY_SLEW_EN, chan 1: 2 -> 6 -> indices 3, 4, 5, 6 on four successive frame_starts. update_pulse only after 6. A write attempted during SLEW is refused (cfg_ready = 0).
